// File: rtl/asteroid_pkg.sv
// Shared constants, slot record and sweep FSM states for the asteroid motion engine.
package asteroid_pkg;

  localparam int unsigned COORD_W_DEF = 8;
  localparam int unsigned VEL_W_DEF   = 4;
  localparam int unsigned X_MAX_DEF   = 160;
  localparam int unsigned Y_MAX_DEF   = 120;

  typedef struct packed {
    logic                   alive;
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [VEL_W_DEF-1:0]   vx;
    logic [VEL_W_DEF-1:0]   vy;
  } slot_t;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

endpackage

// File: rtl/axis_step.sv
// One-axis position step: coordinate plus signed velocity, folded back into 0..limit-1.
module axis_step #(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned VEL_W   = 4
) (
  input  logic [COORD_W-1:0] coord,
  input  logic [VEL_W-1:0]   vel,
  input  logic [COORD_W-1:0] limit,
  output logic [COORD_W-1:0] next_coord,
  output logic               out_of_range
);

  localparam int unsigned T_W = COORD_W + 2;

  logic signed [T_W-1:0] t;
  logic signed [T_W-1:0] lim_s;
  logic signed [T_W-1:0] fixed;

  always_comb begin
    lim_s        = $signed({2'b00, limit});
    t            = $signed({2'b00, coord}) + $signed({{(T_W-VEL_W){vel[VEL_W-1]}}, vel});
    fixed        = t;
    out_of_range = 1'b0;
    // |vel| < limit, so one correction always lands back in range
    if (t < 0) begin
      fixed        = t + lim_s;
      out_of_range = 1'b1;
    end else if (t >= lim_s) begin
      fixed        = t - lim_s;
      out_of_range = 1'b1;
    end
    next_coord = fixed[COORD_W-1:0];
  end

endmodule

// File: rtl/asteroid_motion_engine.sv
// Per-tick sweep of asteroid slots with spawn/kill and a registered read port.
// Build option: ASTEROID_WRAP_EN selects screen wrap; otherwise edge-crossers are killed.
module asteroid_motion_engine #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned IDX_W     = $clog2(NUM_SLOTS),
  parameter int unsigned COORD_W   = asteroid_pkg::COORD_W_DEF,
  parameter int unsigned VEL_W     = asteroid_pkg::VEL_W_DEF,
  parameter int unsigned X_MAX     = asteroid_pkg::X_MAX_DEF,
  parameter int unsigned Y_MAX     = asteroid_pkg::Y_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               move_tick,
  input  logic               spawn_valid,
  output logic               spawn_ready,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] spawn_y,
  input  logic [VEL_W-1:0]   spawn_vx,
  input  logic [VEL_W-1:0]   spawn_vy,
  input  logic               kill_valid,
  input  logic [IDX_W-1:0]   kill_idx,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic               rd_alive,
  output logic               busy,
  output logic               sweep_done,
  output logic [IDX_W:0]     alive_count,
  output logic               tick_overrun
);
  import asteroid_pkg::*;

`ifdef ASTEROID_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  slot_t              slots_q [NUM_SLOTS];
  slot_t              slots_d [NUM_SLOTS];
  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic               pending_q;
  logic               overrun_q;
  logic [IDX_W:0]     alive_count_q;
  logic [IDX_W:0]     alive_cnt_d;
  logic [COORD_W-1:0] rd_x_q, rd_y_q;
  logic               rd_alive_q;

  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  slot_t              cur;
  logic [COORD_W-1:0] nx, ny;
  logic               x_oor, y_oor;

  // Descending scan so the lowest free index is the one left standing
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!slots_q[i].alive) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign spawn_ready = (state_q == IDLE) && free_found && !move_tick && !pending_q;
  assign cur         = slots_q[ptr_q];

  axis_step #(.COORD_W(COORD_W), .VEL_W(VEL_W)) u_step_x (
    .coord       (cur.x),
    .vel         (cur.vx),
    .limit       (COORD_W'(X_MAX)),
    .next_coord  (nx),
    .out_of_range(x_oor)
  );

  axis_step #(.COORD_W(COORD_W), .VEL_W(VEL_W)) u_step_y (
    .coord       (cur.y),
    .vel         (cur.vy),
    .limit       (COORD_W'(Y_MAX)),
    .next_coord  (ny),
    .out_of_range(y_oor)
  );

  // Order matters: sweep write, then kill (wins over sweep), then spawn into a dead slot
  always_comb begin
    for (int i = 0; i < int'(NUM_SLOTS); i++) slots_d[i] = slots_q[i];
    if (state_q == SWEEP && cur.alive) begin
      if (!WRAP_EN && (x_oor || y_oor)) begin
        slots_d[ptr_q].alive = 1'b0;
      end else begin
        slots_d[ptr_q].x = nx;
        slots_d[ptr_q].y = ny;
      end
    end
    if (kill_valid) slots_d[kill_idx].alive = 1'b0;
    if (spawn_valid && spawn_ready) begin
      slots_d[free_idx].alive = 1'b1;
      slots_d[free_idx].x  = (spawn_x >= COORD_W'(X_MAX)) ? COORD_W'(X_MAX - 1) : spawn_x;
      slots_d[free_idx].y  = (spawn_y >= COORD_W'(Y_MAX)) ? COORD_W'(Y_MAX - 1) : spawn_y;
      slots_d[free_idx].vx = spawn_vx;
      slots_d[free_idx].vy = spawn_vy;
    end
  end

  always_comb begin
    alive_cnt_d = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      alive_cnt_d = alive_cnt_d + {{IDX_W{1'b0}}, slots_d[i].alive};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) slots_q[i] <= '0;
      state_q       <= IDLE;
      ptr_q         <= '0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      alive_count_q <= '0;
      rd_x_q        <= '0;
      rd_y_q        <= '0;
      rd_alive_q    <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) slots_q[i] <= slots_d[i];
      alive_count_q <= alive_cnt_d;
      rd_x_q        <= slots_q[rd_idx].x;
      rd_y_q        <= slots_q[rd_idx].y;
      rd_alive_q    <= slots_q[rd_idx].alive;
      if (move_tick && pending_q) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (move_tick || pending_q) begin
            pending_q <= 1'b0;
            ptr_q     <= '0;
            state_q   <= SWEEP;
          end
        end
        SWEEP: begin
          if (move_tick) pending_q <= 1'b1;
          if (ptr_q == IDX_W'(NUM_SLOTS - 1)) state_q <= DONE;
          else ptr_q <= ptr_q + 1'b1;
        end
        DONE: begin
          if (move_tick) pending_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign sweep_done   = (state_q == DONE);
  assign alive_count  = alive_count_q;
  assign tick_overrun = overrun_q;
  assign rd_x         = rd_x_q;
  assign rd_y         = rd_y_q;
  assign rd_alive     = rd_alive_q;

endmodule
